// File: rtl/elevator_pkg.sv
// Shared request-code definitions and sequencer state type used by the
// floor request encoder and the downstream management block.
package elevator_pkg;

  localparam int REQ_CODE_W = 4;
  localparam logic [REQ_CODE_W-1:0] REQ_NONE = 4'b0000;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    STROBE  = 2'd2,
    HOLD    = 2'd3
  } state_t;

  // Button index i is reported as code i+1 so that code 0 can mean "no request".
  function automatic logic [REQ_CODE_W-1:0] idx_to_code(input logic [REQ_CODE_W-1:0] idx);
    return idx + 4'd1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-flop synchroniser, stability counter and a one-cycle pulse
// when the debounced level goes from released to pressed.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic rise
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      rise  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      // The level only follows after DEBOUNCE_CYCLES consecutive differing samples.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync2;
        rise  <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/floor_request_encoder.sv
// Debounces floor/cabin buttons into a sticky pending set and serves one
// request at a time as code + strobe. Define REQ_ROUND_ROBIN_EN for round-robin arbitration.
module floor_request_encoder
  import elevator_pkg::*;
#(
  parameter int NUM_BTN         = 11,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETUP_CYCLES    = 1,
  parameter int STROBE_CYCLES   = 1,
  parameter int HOLD_CYCLES     = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_BTN-1:0]    btn_in,
  input  logic                  mgmt_ready,
  output logic [REQ_CODE_W-1:0] BCD_out,
  output logic                  req_strobe,
  output logic [NUM_BTN-1:0]    pending,
  output logic                  busy,
  output state_t                fsm_state
);

  localparam int MAX_ST    = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int MAX_PHASE = (MAX_ST > HOLD_CYCLES) ? MAX_ST : HOLD_CYCLES;
  localparam int PH_W      = $clog2(MAX_PHASE) + 1;
  localparam logic [PH_W-1:0] SETUP_LAST  = PH_W'(SETUP_CYCLES - 1);
  localparam logic [PH_W-1:0] STROBE_LAST = PH_W'(STROBE_CYCLES - 1);
  localparam logic [PH_W-1:0] HOLD_LAST   = PH_W'(HOLD_CYCLES - 1);

  state_t                state;
  state_t                state_next;
  logic [PH_W-1:0]       phase;
  logic [PH_W-1:0]       phase_next;
  logic [REQ_CODE_W-1:0] sel;
  logic [REQ_CODE_W-1:0] sel_next;
  logic [REQ_CODE_W-1:0] win_idx;
  logic                  win_valid;
  logic [NUM_BTN-1:0]    rise;
  logic [NUM_BTN-1:0]    clr;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk (CLK),
      .rst (RST),
      .btn (btn_in[i]),
      .rise(rise[i])
    );
  end

  assign win_valid = |pending;

`ifdef REQ_ROUND_ROBIN_EN
  logic [REQ_CODE_W-1:0] ptr;

  // Search order starts just after the last served index and wraps.
  always_comb begin
    logic [REQ_CODE_W-1:0] idx;
    win_idx = '0;
    idx     = '0;
    for (int k = NUM_BTN; k >= 1; k--) begin
      idx = REQ_CODE_W'((int'(ptr) + k) % NUM_BTN);
      if (pending[idx]) win_idx = idx;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr <= REQ_CODE_W'(NUM_BTN - 1);
    end else if (state == IDLE && state_next == PRESENT) begin
      ptr <= win_idx;
    end
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (pending[i]) win_idx = REQ_CODE_W'(i);
    end
  end
`endif

  // Handshake: mgmt_ready is a level sampled only in IDLE; once a sequence
  // starts it runs to completion regardless of mgmt_ready.
  always_comb begin
    state_next = state;
    phase_next = phase + 1'b1;
    sel_next   = sel;
    clr        = '0;
    unique case (state)
      IDLE: begin
        phase_next = '0;
        if (win_valid && mgmt_ready) begin
          state_next = PRESENT;
          sel_next   = win_idx;
        end
      end
      PRESENT: begin
        if (phase == SETUP_LAST) begin
          state_next = STROBE;
          phase_next = '0;
        end
      end
      STROBE: begin
        if (phase == STROBE_LAST) begin
          state_next = HOLD;
          phase_next = '0;
        end
      end
      HOLD: begin
        if (phase == HOLD_LAST) begin
          state_next = IDLE;
          phase_next = '0;
          clr        = NUM_BTN'(1) << sel;
        end
      end
      default: begin
        state_next = IDLE;
        phase_next = '0;
      end
    endcase
  end

  // A new debounced press wins over the clear, so a same-cycle re-press re-pends.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      phase   <= '0;
      sel     <= '0;
      pending <= '0;
    end else begin
      state   <= state_next;
      phase   <= phase_next;
      sel     <= sel_next;
      pending <= (pending & ~clr) | rise;
    end
  end

  assign BCD_out    = (state == IDLE) ? REQ_NONE : idx_to_code(sel);
  assign req_strobe = (state == STROBE);
  assign busy       = (state != IDLE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_floor_request_encoder.sv
// Bench for floor_request_encoder: directed scenarios plus random button and
// ready traffic, checked cycle by cycle against a behavioural model.
module tb_floor_request_encoder;
  import elevator_pkg::*;

  localparam int NUM_BTN = 11;
  localparam int DEB     = 4;
  localparam int SETUP   = 1;
  localparam int STRB    = 1;
  localparam int HOLDC   = 1;
  localparam int SEQ_LEN = SETUP + STRB + HOLDC;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [NUM_BTN-1:0]  btn = '0;
  logic                ready = 1'b0;
  logic [3:0]          bcd;
  logic                strobe;
  logic [NUM_BTN-1:0]  pending;
  logic                busy;
  state_t              fsm_state;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_chk_print = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  floor_request_encoder #(
    .NUM_BTN(NUM_BTN), .DEBOUNCE_CYCLES(DEB), .SETUP_CYCLES(SETUP),
    .STROBE_CYCLES(STRB), .HOLD_CYCLES(HOLDC)
  ) dut (
    .CLK(clk), .RST(rst), .btn_in(btn), .mgmt_ready(ready),
    .BCD_out(bcd), .req_strobe(strobe), .pending(pending), .busy(busy),
    .fsm_state(fsm_state)
  );

  // ---------------- behavioural reference model ----------------
  logic [NUM_BTN-1:0] m_pend, m_deb, m_rise, m_clr;
  logic               m_active;
  int                 m_t, m_sel;
  logic               all_diff;
  logic [NUM_BTN-1:0] hist[$];
  logic [3:0]         exp_q[$];
  logic [3:0]         served_q[$];
  logic               prev_strobe = 1'b0;
`ifdef REQ_ROUND_ROBIN_EN
  int                 m_ptr;
`endif

  function automatic int pick(input logic [NUM_BTN-1:0] p);
`ifdef REQ_ROUND_ROBIN_EN
    for (int k = 1; k <= NUM_BTN; k++) begin
      if (p[(m_ptr + k) % NUM_BTN]) return (m_ptr + k) % NUM_BTN;
    end
`else
    for (int i = 0; i < NUM_BTN; i++) begin
      if (p[i]) return i;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_pend = '0; m_deb = '0; m_rise = '0; m_active = 1'b0; m_t = 0; m_sel = 0;
`ifdef REQ_ROUND_ROBIN_EN
      m_ptr = NUM_BTN - 1;
`endif
      hist.delete();
      for (int k = 0; k < DEB + 2; k++) hist.push_back('0);
      exp_q.delete();
    end else begin
      m_clr = '0;
      if (m_active) begin
        if (m_t == SEQ_LEN - 1) begin
          m_clr[m_sel] = 1'b1;
          m_active = 1'b0;
        end else begin
          m_t++;
        end
      end else if (m_pend != '0 && ready) begin
        m_sel = pick(m_pend);
`ifdef REQ_ROUND_ROBIN_EN
        m_ptr = m_sel;
`endif
        m_active = 1'b1;
        m_t = 0;
        exp_q.push_back(4'(m_sel + 1));
      end
      m_pend = (m_pend & ~m_clr) | m_rise;
      // Debounced level flips once DEB consecutive synchronised samples disagree.
      m_rise = '0;
      for (int i = 0; i < NUM_BTN; i++) begin
        all_diff = 1'b1;
        for (int k = 0; k < DEB; k++) begin
          if (hist[hist.size() - 2 - k][i] == m_deb[i]) all_diff = 1'b0;
        end
        if (all_diff) begin
          m_deb[i]  = ~m_deb[i];
          m_rise[i] = m_deb[i];
        end
      end
      hist.push_back(btn);
      void'(hist.pop_front());
    end
  end

  // ---------------- cycle scoreboard ----------------
  always @(negedge clk) begin
    logic [3:0] m_bcd;
    logic       m_strb;
    if (chk_en) begin
      m_bcd  = m_active ? 4'(m_sel + 1) : 4'd0;
      m_strb = m_active && (m_t >= SETUP) && (m_t < SETUP + STRB);
      n_cmp += 4;
      if (bcd !== m_bcd) begin
        n_fail++;
        if (n_chk_print < 30) $display("FAIL model_bcd t=%0t got %0d want %0d", $time, bcd, m_bcd);
        n_chk_print++;
      end
      if (strobe !== m_strb) begin
        n_fail++;
        if (n_chk_print < 30) $display("FAIL model_strobe t=%0t got %0b want %0b", $time, strobe, m_strb);
        n_chk_print++;
      end
      if (pending !== m_pend) begin
        n_fail++;
        if (n_chk_print < 30) $display("FAIL model_pending t=%0t got %h want %h", $time, pending, m_pend);
        n_chk_print++;
      end
      if (busy !== m_active) begin
        n_fail++;
        if (n_chk_print < 30) $display("FAIL model_busy t=%0t got %0b want %0b", $time, busy, m_active);
        n_chk_print++;
      end
      if (strobe === 1'b1 && prev_strobe === 1'b0) begin
        served_q.push_back(bcd);
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_unexpected_strobe t=%0t got code %0d want no strobe", $time, bcd);
        end else begin
          logic [3:0] e;
          e = exp_q.pop_front();
          if (bcd !== e) begin
            n_fail++;
            $display("FAIL sb_code t=%0t got %0d want %0d", $time, bcd, e);
          end
        end
      end
      prev_strobe = strobe;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int c;
    rst = 1'b1; btn = '0; ready = 1'b0;
    tick(2);
    chk_en = 1'b1;
    n_cmp++;
    if ({bcd, strobe, pending, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_init got bcd=%0d strb=%0b pend=%h busy=%0b want all 0", bcd, strobe, pending, busy);
    end
    rst = 1'b0;
    btn[4] = 1'b1; ready = 1'b1;
    c = 0;
    while (strobe !== 1'b1 && c < 30) begin tick(1); c++; end
    n_cmp++;
    if (strobe !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_reach_strobe got no strobe within %0d cycles want strobe", c);
    end
    btn = '0; rst = 1'b1;
    tick(1);
    rst = 1'b0;
    n_cmp++;
    if ({bcd, strobe, pending, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_strobe got bcd=%0d strb=%0b pend=%h busy=%0b want all 0", bcd, strobe, pending, busy);
    end
    tick(DEB + 4);
  endtask

  task automatic test_single_press();
    int pend_at = -1, bcd_at = -1, strb_at = -1, strb_cnt = 0;
    ready = 1'b1;
    btn[10] = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick(1);
      if (c == 10) btn[10] = 1'b0;
      if (pending[10] === 1'b1 && pend_at < 0) pend_at = c;
      if (bcd === 4'b1011 && bcd_at < 0) bcd_at = c;
      if (strobe === 1'b1) begin
        strb_cnt++;
        if (strb_at < 0) strb_at = c;
      end
    end
    n_cmp++;
    if (pend_at < 1 || pend_at > 2 + DEB + 1) begin
      n_fail++;
      $display("FAIL single_latency got %0d want 1..%0d", pend_at, 2 + DEB + 1);
    end
    n_cmp++;
    if (bcd_at < 0 || strb_at - bcd_at != SETUP) begin
      n_fail++;
      $display("FAIL single_setup got code_at=%0d strobe_at=%0d want gap %0d", bcd_at, strb_at, SETUP);
    end
    n_cmp++;
    if (strb_cnt != STRB) begin
      n_fail++;
      $display("FAIL single_strobe_len got %0d want %0d", strb_cnt, STRB);
    end
    n_cmp++;
    if (pending[10] !== 1'b0) begin
      n_fail++;
      $display("FAIL single_clear got %0b want 0", pending[10]);
    end
  endtask

  task automatic test_bounce();
    logic seen_pend = 1'b0, seen_strb = 1'b0;
    ready = 1'b1;
    served_q.delete();
    for (int c = 0; c < 12; c++) begin
      btn[0] = ((c / 2) % 2 == 0);
      tick(1);
      if (pending !== '0) seen_pend = 1'b1;
      if (strobe !== 1'b0) seen_strb = 1'b1;
    end
    btn[0] = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (pending !== '0) seen_pend = 1'b1;
      if (strobe !== 1'b0) seen_strb = 1'b1;
    end
    n_cmp++;
    if (seen_pend || seen_strb) begin
      n_fail++;
      $display("FAIL bounce got pend_seen=%0b strobe_seen=%0b want 0 0", seen_pend, seen_strb);
    end
  endtask

  task automatic test_simultaneous();
    logic [3:0] want0, want1;
    ready = 1'b1;
    btn[1] = 1'b1; tick(8); btn[1] = 1'b0; tick(15);
    served_q.delete();
    btn[1] = 1'b1; btn[3] = 1'b1; tick(8);
    btn[1] = 1'b0; btn[3] = 1'b0; tick(20);
`ifdef REQ_ROUND_ROBIN_EN
    want0 = 4'b0100; want1 = 4'b0010;
`else
    want0 = 4'b0010; want1 = 4'b0100;
`endif
    n_cmp++;
    if (served_q.size() != 2) begin
      n_fail++;
      $display("FAIL simul_count got %0d want 2", served_q.size());
    end else if (served_q[0] !== want0 || served_q[1] !== want1) begin
      n_fail++;
      $display("FAIL simul_order got %0d,%0d want %0d,%0d", served_q[0], served_q[1], want0, want1);
    end
  endtask

  task automatic test_flow_control();
    int c;
    logic held_zero = 1'b1;
    ready = 1'b0;
    btn[5] = 1'b1; tick(8); btn[5] = 1'b0;
    n_cmp++;
    if (pending[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL flow_pending got %0b want 1", pending[5]);
    end
    for (int k = 0; k < 10; k++) begin
      tick(1);
      if (bcd !== 4'd0) held_zero = 1'b0;
    end
    n_cmp++;
    if (!held_zero) begin
      n_fail++;
      $display("FAIL flow_blocked got nonzero code want 0");
    end
    ready = 1'b1;
    tick(1);
    n_cmp++;
    if (bcd !== 4'b0110 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL flow_present got code=%0d busy=%0b want 6 1", bcd, busy);
    end
    c = 0;
    while (strobe !== 1'b1 && c < 5) begin tick(1); c++; end
    ready = 1'b0;
    tick(1);
    n_cmp++;
    if (strobe !== 1'b0 || bcd !== 4'b0110) begin
      n_fail++;
      $display("FAIL flow_hold got strb=%0b code=%0d want 0 6", strobe, bcd);
    end
    tick(1);
    n_cmp++;
    if (busy !== 1'b0 || pending[5] !== 1'b0) begin
      n_fail++;
      $display("FAIL flow_done got busy=%0b pend5=%0b want 0 0", busy, pending[5]);
    end
    tick(8);
  endtask

  task automatic test_repress();
    ready = 1'b0;
    btn[2] = 1'b1; tick(8); btn[2] = 1'b0; tick(10);
    served_q.delete();
    // Re-press timed so its debounced edge coincides with the final HOLD cycle.
    btn[2] = 1'b1;
    tick(3);
    ready = 1'b1;
    tick(4);
    n_cmp++;
    if (pending[2] !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL repress_repend got pend2=%0b busy=%0b want 1 0", pending[2], busy);
    end
    tick(12);
    n_cmp++;
    if (served_q.size() != 2 || served_q[0] !== 4'b0011 || served_q[1] !== 4'b0011) begin
      n_fail++;
      $display("FAIL repress_twice got %0d sequences want two of code 3", served_q.size());
    end
    btn[2] = 1'b0;
    tick(10);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
      end
      ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    btn = '0; ready = 1'b1;
    tick(150);
    n_cmp++;
    if (exp_q.size() != 0 || pending !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL random_drain got q=%0d pend=%h busy=%0b want 0 0 0", exp_q.size(), pending, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_flow_control();
    test_repress();
    test_random();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1);
  end

endmodule
